md_sequencer: RTL

- Sequences the iterative multiply/divide resource that executes MULT, MULTU, DIV and DIVU.
- Owns the HI/LO registers and serves MTHI/MTLO/MFHI/MFLO.
- Drives a stall request into the hazard unit while a multi-cycle operation is in flight.
- Sits beside the ALU in the Execute stage. Starts are issued from E; HI/LO reads and writes come from D/E.

---
 rtl/md_pkg.sv | 27 ++
 rtl/md_if.sv | 29 ++
 rtl/md_iter_step.sv | 36 +++
 rtl/md_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states,
// iteration count and the divide-by-zero LO value.
package md_pkg;

    localparam int          MD_ITER       = 32;
    localparam logic [31:0] MD_DIVZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } mdState_t;

    // MULT and DIV are the signed flavours (op bit 0 clear).
    function automatic logic isSignedOp(input logic [1:0] op);
        return !op[0];
    endfunction

endpackage

// File: rtl/md_if.sv
// Execute-stage bundle between the pipeline (master) and the MD sequencer (slave).
interface md_if #(parameter int XLEN = 32);

    logic            startE;
    logic [1:0]      mdOpE;
    logic [XLEN-1:0] srcAE;
    logic [XLEN-1:0] srcBE;
    logic            mtHiE;
    logic            mtLoE;
    logic [XLEN-1:0] mtDataE;
    logic            mdUseD;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            busy;
    logic            stallMD;
    logic            done;
    logic            divZero;

    modport master (
        output startE, mdOpE, srcAE, srcBE, mtHiE, mtLoE, mtDataE, mdUseD,
        input  hi, lo, busy, stallMD, done, divZero
    );

    modport slave (
        input  startE, mdOpE, srcAE, srcBE, mtHiE, mtLoE, mtDataE, mdUseD,
        output hi, lo, busy, stallMD, done, divZero
    );

endinterface

// File: rtl/md_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module md_iter_step #(
    parameter int XLEN = 32
) (
    input  logic              isDiv,
    input  logic [2*XLEN-1:0] acc,
    input  logic [2*XLEN-1:0] mcand,
    input  logic [XLEN-1:0]   mplier,
    output logic [2*XLEN-1:0] accNext,
    output logic [2*XLEN-1:0] mcandNext,
    output logic [XLEN-1:0]   mplierNext
);

    // Divide keeps {remainder, dividend/quotient} in acc; remainder < divisor,
    // so bit XLEN of the trial difference is a clean borrow flag.
    logic [XLEN:0] trial;

    always_comb begin
        trial      = acc[2*XLEN-1:XLEN-1] - {1'b0, mplier};
        accNext    = acc;
        mcandNext  = mcand;
        mplierNext = mplier;
        if (isDiv) begin
            if (!trial[XLEN])
                accNext = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                accNext = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            if (mplier[0])
                accNext = acc + mcand;
            mcandNext  = {mcand[2*XLEN-2:0], 1'b0};
            mplierNext = {1'b0, mplier[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Define MD_EARLY_TERM_EN to let MUL finish once the remaining multiplier bits are zero.
//
// state   | meaning
// IDLE    | waiting; serves MTHI/MTLO; a start loads magnitudes and signs
// MUL     | one shift-add iteration per cycle
// DIV     | one restoring-divide iteration per cycle
// FIX     | sign correction and HI/LO write-back
module md_sequencer
    import md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic i_clk,
    input logic i_rst_n,
    md_if.slave md
);

    mdState_t          state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   hiReg;
    logic [XLEN-1:0]   loReg;
    logic              isDiv;
    logic              negRes;
    logic              negRem;
    logic              busy;
    logic              done;
    logic              divZero;

    logic [2*XLEN-1:0] accNext;
    logic [2*XLEN-1:0] mcandNext;
    logic [XLEN-1:0]   mplierNext;
    logic              sgn;
    logic [XLEN-1:0]   absA;
    logic [XLEN-1:0]   absB;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   quotFix;
    logic [XLEN-1:0]   remFix;
    logic              lastIter;

    md_iter_step #(.XLEN(XLEN)) uStep (
        .isDiv      (isDiv),
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .accNext    (accNext),
        .mcandNext  (mcandNext),
        .mplierNext (mplierNext)
    );

    always_comb begin
        sgn  = isSignedOp(md.mdOpE);
        absA = (sgn && md.srcAE[XLEN-1]) ? -md.srcAE : md.srcAE;
        absB = (sgn && md.srcBE[XLEN-1]) ? -md.srcBE : md.srcBE;
    end

    always_comb begin
        prodFix = negRes ? -acc : acc;
        quotFix = negRes ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remFix  = negRem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    always_comb begin
        lastIter = (cnt == CNT_W'(MD_ITER - 1));
`ifdef MD_EARLY_TERM_EN
        if (!isDiv && mplierNext == '0)
            lastIter = 1'b1;
`else
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (md.startE) begin
                        isDiv  <= md.mdOpE[1];
                        negRes <= sgn & (md.srcAE[XLEN-1] ^ md.srcBE[XLEN-1]);
                        negRem <= sgn & md.srcAE[XLEN-1];
                        // Divide parks the raw rs in mcand for the divide-by-zero result.
                        acc    <= md.mdOpE[1] ? {{XLEN{1'b0}}, absA} : '0;
                        mcand  <= md.mdOpE[1] ? {{XLEN{1'b0}}, md.srcAE}
                                              : {{XLEN{1'b0}}, absA};
                        mplier  <= absB;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        divZero <= 1'b0;
                        state   <= md.mdOpE[1] ? ST_DIV : ST_MUL;
                    end else begin
                        if (md.mtHiE)
                            hiReg <= md.mtDataE;
                        if (md.mtLoE)
                            loReg <= md.mtDataE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc    <= accNext;
                    mcand  <= mcandNext;
                    mplier <= mplierNext;
                    cnt    <= cnt + CNT_W'(1);
                    if (lastIter)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    if (isDiv) begin
                        if (mplier == '0) begin
                            hiReg   <= mcand[XLEN-1:0];
                            loReg   <= XLEN'(MD_DIVZERO_LO);
                            divZero <= 1'b1;
                        end else begin
                            hiReg <= remFix;
                            loReg <= quotFix;
                        end
                    end else begin
                        hiReg <= prodFix[2*XLEN-1:XLEN];
                        loReg <= prodFix[XLEN-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign md.hi      = hiReg;
    assign md.lo      = loReg;
    assign md.busy    = busy;
    assign md.done    = done;
    assign md.divZero = divZero;
    assign md.stallMD = busy & md.mdUseD;

    // The hazard unit must keep starts and MT* out of E while an operation is in flight.
    noIssueWhileBusy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        busy |-> !(md.startE || md.mtHiE || md.mtLoE));

endmodule
